// File: rtl/dial_quad_gen.sv
// dial_quad_gen: spinner (dial) pulse generator for a game input port.
//
// Converts held clockwise/counter-clockwise controls and signed relative
// movement (mouse/paddle deltas) into single-step pulses on a two-line
// spinner port. Each step is one tick of the active level followed by at
// least one idle tick. A direction change therefore always passes through
// the idle level 2'b11.
//
// Optional feature (build-time macro DIAL_ACCEL_EN):
//   When it is defined, repeated held steps in the same direction shorten
//   the tick period by 2 cycles per step, down to ACC_MIN. When it is
//   undefined, the period is fixed at TICK_DIV and no acceleration state
//   exists.
//
// Parameters:
//   TICK_DIV     clock cycles per tick at rest speed (4..255)
//   ACC_MIN      minimum tick period under acceleration (2..TICK_DIV)
//
// Ports:
//   clock_12     in   1  system clock; all logic runs on its rising edge
//   reset        in   1  synchronous, active-high reset
//   inc          in   1  held "rotate clockwise" level
//   dec          in   1  held "rotate counter-clockwise" level
//   delta_valid  in   1  one-cycle strobe qualifying delta
//   delta        in   8  signed relative movement
//   dial         out  2  spinner lines: idle 2'b11, cw 2'b10, ccw 2'b01
//   busy         out  1  pulse in progress or accumulator non-zero

module dial_quad_gen #(
    parameter int unsigned TICK_DIV = 32,
    parameter int unsigned ACC_MIN  = 8
) (
    input  logic       clock_12,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       delta_valid,
    input  logic [7:0] delta,
    output logic [1:0] dial,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned SUM_W = 10;

    localparam logic [1:0] DIAL_IDLE = 2'b11;
    localparam logic [1:0] DIAL_INC  = 2'b10;
    localparam logic [1:0] DIAL_DEC  = 2'b01;

    localparam logic [CNT_W-1:0] TICK_DIV_W = CNT_W'(TICK_DIV);

    // Reject illegal parameter combinations at elaboration.
    if (TICK_DIV < 4 || TICK_DIV > 255 || ACC_MIN < 2 || ACC_MIN > TICK_DIV) begin : g_param_check
        $error("dial_quad_gen: TICK_DIV must be 4..255 and ACC_MIN 2..TICK_DIV");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        P_INC = 2'd1,
        P_DEC = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        period;
    logic                    tick;
    logic                    held_inc;
    logic                    held_dec;
    logic                    drain_pos;
    logic                    drain_neg;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic        [ACC_W-1:0] delta_eff;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] delta_ext;
    logic signed [SUM_W-1:0] drain_ext;
    logic signed [SUM_W-1:0] sum;

    // Both controls high is treated as no held input.
    assign held_inc = inc & ~dec;
    assign held_dec = dec & ~inc;

    assign tick = (count == (period - CNT_W'(1)));

`ifdef DIAL_ACCEL_EN
    localparam logic [CNT_W-1:0] ACC_MIN_W = CNT_W'(ACC_MIN);

    logic [CNT_W-1:0] period_q;
    logic             last_dir;     // 1 = last held step was counter-clockwise
    logic             last_valid;   // a held step happened since the last rest
    logic             step_dir;

    assign period   = period_q;
    assign step_dir = held_dec;

    // Period tracking: only held-control steps started from IDLE accelerate.
    // The new value is loaded on the tick itself, so it governs the count
    // sequence that begins at this wrap.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            period_q   <= TICK_DIV_W;
            last_dir   <= 1'b0;
            last_valid <= 1'b0;
        end else if (tick && state == IDLE) begin
            if (held_inc || held_dec) begin
                if (last_valid && last_dir == step_dir) begin
                    if ((period_q - ACC_MIN_W) >= CNT_W'(2)) begin
                        period_q <= period_q - CNT_W'(2);
                    end else begin
                        period_q <= ACC_MIN_W;
                    end
                end else begin
                    period_q <= TICK_DIV_W;
                end
                last_dir   <= step_dir;
                last_valid <= 1'b1;
            end else begin
                period_q   <= TICK_DIV_W;
                last_valid <= 1'b0;
            end
        end
    end
`else
    assign period = TICK_DIV_W;
`endif

    // Next-state and accumulator drain decision; only ticks cause transitions.
    always_comb begin
        next_state = state;
        drain_pos  = 1'b0;
        drain_neg  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (held_inc) begin
                        next_state = P_INC;
                    end else if (held_dec) begin
                        next_state = P_DEC;
                    end else if (acc > ACC_W'(signed'(0))) begin
                        next_state = P_INC;
                        drain_pos  = 1'b1;
                    end else if (acc < ACC_W'(signed'(0))) begin
                        next_state = P_DEC;
                        drain_neg  = 1'b1;
                    end
                end
                P_INC, P_DEC: next_state = IDLE;
                default:      next_state = IDLE;
            endcase
        end
    end

    // Accumulator update: add the qualified delta, remove this cycle's drain,
    // saturate symmetrically to +/-127 in 10-bit signed arithmetic.
    always_comb begin
        delta_eff = (delta == 8'h80) ? 8'h81 : delta;
        acc_ext   = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
        delta_ext = delta_valid ? {{(SUM_W-ACC_W){delta_eff[ACC_W-1]}}, delta_eff}
                                : SUM_W'(0);
        if (drain_pos) begin
            drain_ext = SUM_W'(1);
        end else if (drain_neg) begin
            drain_ext = '1;
        end else begin
            drain_ext = '0;
        end
        sum = acc_ext + delta_ext - drain_ext;
        if (sum > 10'sd127) begin
            acc_next = 8'sd127;
        end else if (sum < -10'sd127) begin
            acc_next = -8'sd127;
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
    end

    // State, dial, accumulator and tick counter registers.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            state <= IDLE;
            dial  <= DIAL_IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            unique case (next_state)
                P_INC:   dial <= DIAL_INC;
                P_DEC:   dial <= DIAL_DEC;
                default: dial <= DIAL_IDLE;
            endcase
            acc   <= acc_next;
            count <= tick ? CNT_W'(0) : count + CNT_W'(1);
        end
    end

    assign busy = (state != IDLE) | (acc != ACC_W'(signed'(0)));

endmodule

// File: tb/tb_dial_quad_gen.sv
// Scoreboard bench for dial_quad_gen (default build, TICK_DIV=32).
// Stimulus pushes hand-computed {cycle, value} change events for dial and
// busy; a negedge monitor pops one event on every observed change.
// cyc counts rising edges since reset release, so the first tick's effect
// is seen at cyc 32, the k-th tick's at cyc 32*k.

module tb_dial_quad_gen;

    logic       clock_12 = 1'b0;
    logic       reset = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       delta_valid = 1'b0;
    logic [7:0] delta = 8'd0;
    logic [1:0] dial;
    logic       busy;

    typedef struct packed {
        int         cyc;
        logic [1:0] val;
    } ev_t;

    ev_t        dial_q[$];
    ev_t        busy_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [1:0] prev_dial = 2'b11;
    logic       prev_busy = 1'b0;

    dial_quad_gen #(.TICK_DIV(32), .ACC_MIN(8)) dut (
        .clock_12    (clock_12),
        .reset       (reset),
        .inc         (inc),
        .dec         (dec),
        .delta_valid (delta_valid),
        .delta       (delta),
        .dial        (dial),
        .busy        (busy)
    );

    always #5 clock_12 = ~clock_12;

    always @(posedge clock_12) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Monitor: every change of dial or busy must match the next expected event.
    always @(negedge clock_12) begin
        ev_t e;
        if (mon_en) begin
            if (dial !== prev_dial) begin
                n_tests++;
                if (dial_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dial_unexpected: got %b at cyc %0d, required no change", dial, cyc);
                end else begin
                    e = dial_q.pop_front();
                    if (e.cyc != cyc || e.val !== dial) begin
                        n_fail++;
                        $display("FAIL dial_event: got %b at cyc %0d, required %b at cyc %0d",
                                 dial, cyc, e.val, e.cyc);
                    end
                end
                prev_dial = dial;
            end
            if (busy !== prev_busy) begin
                n_tests++;
                if (busy_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL busy_unexpected: got %b at cyc %0d, required no change", busy, cyc);
                end else begin
                    e = busy_q.pop_front();
                    if (e.cyc != cyc || e.val[0] !== busy) begin
                        n_fail++;
                        $display("FAIL busy_event: got %b at cyc %0d, required %b at cyc %0d",
                                 busy, cyc, e.val[0], e.cyc);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    function automatic void exp_dial(input int c, input logic [1:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        dial_q.push_back(e);
    endfunction

    function automatic void exp_busy(input int c, input logic b);
        ev_t e;
        e.cyc = c;
        e.val = {1'b0, b};
        busy_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 20000) begin
            @(negedge clock_12);
            guard++;
        end
        if (cyc != c) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_timeout: cyc %0d, required %0d", cyc, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_12);
        reset = 1'b1;
        repeat (3) @(negedge clock_12);
        reset = 1'b0;
    endtask

    task automatic pulse_delta(input int c, input logic [7:0] d);
        wait_cyc(c);
        delta_valid = 1'b1;
        delta       = d;
        @(negedge clock_12);
        delta_valid = 1'b0;
        delta       = 8'd0;
    endtask

    task automatic end_check(input string name);
        n_tests++;
        if (dial_q.size() != 0 || busy_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d dial / %0d busy events left, required 0 / 0",
                     name, dial_q.size(), busy_q.size());
        end
        dial_q.delete();
        busy_q.delete();
    endtask

    task automatic check_rest(input string name);
        n_tests++;
        if (dial !== 2'b11 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rest: dial %b busy %b, required dial 11 busy 0", name, dial, busy);
        end
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Idle after reset: no activity for 200 cycles.
        check_rest("reset");
        wait_cyc(200);
        check_rest("idle");
        end_check("idle");

        // inc held: 11,10,11,10 each 32 cycles.
        inc = 1'b1;
        do_reset();
        exp_dial(32, 2'b10); exp_dial(64, 2'b11); exp_dial(96, 2'b10); exp_dial(128, 2'b11);
        exp_busy(32, 1'b1);  exp_busy(64, 1'b0);  exp_busy(96, 1'b1);  exp_busy(128, 1'b0);
        wait_cyc(130);
        inc = 1'b0;
        wait_cyc(200);
        end_check("inc_held");

        // delta +3: three cw pulses on alternating ticks.
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b10);  exp_dial(64, 2'b11);  exp_dial(96, 2'b10);
        exp_dial(128, 2'b11); exp_dial(160, 2'b10); exp_dial(192, 2'b11);
        exp_busy(192, 1'b0);
        pulse_delta(5, 8'd3);
        wait_cyc(230);
        end_check("delta_p3");

        // delta -2: two ccw pulses.
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b01); exp_dial(64, 2'b11); exp_dial(96, 2'b01); exp_dial(128, 2'b11);
        exp_busy(128, 1'b0);
        pulse_delta(5, 8'hFE);
        wait_cyc(200);
        end_check("delta_m2");

        // Saturation: +100 then +100 back-to-back gives exactly 127 pulses.
        do_reset();
        exp_busy(6, 1'b1);
        for (int k = 1; k <= 254; k++) begin
            exp_dial(32 * k, (k % 2 == 1) ? 2'b10 : 2'b11);
        end
        exp_busy(8128, 1'b0);
        pulse_delta(5, 8'd100);
        pulse_delta(6, 8'd100);
        wait_cyc(8200);
        end_check("saturate");

        // Strobe coinciding with a drain tick: 5 - 3 - 1 = 1 left after the tick.
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b10); exp_dial(64, 2'b11); exp_dial(96, 2'b10); exp_dial(128, 2'b11);
        exp_busy(128, 1'b0);
        pulse_delta(5, 8'd5);
        pulse_delta(31, 8'hFD);
        wait_cyc(200);
        end_check("drain_same_cycle");

        // -128 acts as -127: 1 + (-127) + 125 = -1, one ccw pulse.
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b01); exp_dial(64, 2'b11);
        exp_busy(64, 1'b0);
        pulse_delta(5, 8'd1);
        pulse_delta(6, 8'h80);
        pulse_delta(7, 8'd125);
        wait_cyc(130);
        end_check("delta_m128");

        // inc and dec both high: no movement, but the accumulator still drains.
        inc = 1'b1;
        dec = 1'b1;
        do_reset();
        wait_cyc(100);
        check_rest("both_held");
        end_check("both_held");
        exp_busy(101, 1'b1);
        exp_dial(128, 2'b10); exp_dial(160, 2'b11);
        exp_busy(160, 1'b0);
        pulse_delta(100, 8'd1);
        wait_cyc(200);
        inc = 1'b0;
        dec = 1'b0;
        end_check("both_held_drain");

        // Direction reversal mid-pulse passes through 11.
        inc = 1'b1;
        do_reset();
        exp_dial(32, 2'b10); exp_dial(64, 2'b11); exp_dial(96, 2'b01); exp_dial(128, 2'b11);
        exp_busy(32, 1'b1);  exp_busy(64, 1'b0);  exp_busy(96, 1'b1);  exp_busy(128, 1'b0);
        wait_cyc(40);
        inc = 1'b0;
        dec = 1'b1;
        wait_cyc(130);
        dec = 1'b0;
        wait_cyc(200);
        end_check("reversal");

        // Held control wins over a pending accumulator without draining it.
        inc = 1'b1;
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b10);  exp_dial(64, 2'b11);  exp_dial(96, 2'b10);
        exp_dial(128, 2'b11); exp_dial(160, 2'b10); exp_dial(192, 2'b11);
        exp_busy(192, 1'b0);
        pulse_delta(5, 8'd2);
        wait_cyc(40);
        inc = 1'b0;
        wait_cyc(230);
        end_check("held_priority");

        // Reset mid-pulse: dial back to 11 at once, pending accumulator discarded.
        inc = 1'b1;
        do_reset();
        exp_busy(6, 1'b1);
        exp_dial(32, 2'b10);
        pulse_delta(5, 8'd5);
        wait_cyc(40);
        exp_dial(0, 2'b11);
        exp_busy(0, 1'b0);
        inc = 1'b0;
        do_reset();
        wait_cyc(200);
        check_rest("reset_mid");
        end_check("reset_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
